// File: rtl/lmt_search_ctrl.sv
// Lookup controller for the TCAM PMT pool: fans a key out to every PMT owned by
// the requested LMT, resolves the lowest-index match and keeps lookup/hit statistics.
//
// state    | meaning
// S_IDLE   | ready for a request; snapshot key, LMT and ownership mask on accept
// S_SEARCH | search_en pulse to owned PMTs
// S_WAIT   | extra pool latency beyond one cycle (skipped when SEARCH_LAT == 1)
// S_SAMPLE | pool results valid; resolve winner into response registers
// S_RESP   | response presented until resp_ready
module lmt_search_ctrl #(
  parameter int NUM_PMTS     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int PMT_ID_WIDTH = 6,
  parameter int SEARCH_LAT   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PMTS-1:0]            pmt_used,
  input  logic [NUM_PMTS*8-1:0]          pmt_lmt_id,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [DATA_WIDTH-1:0]          req_key,
  input  logic [7:0]                     req_lmt_id,
  output logic [NUM_PMTS-1:0]            search_en,
  output logic [NUM_PMTS*DATA_WIDTH-1:0] search_key,
  input  logic [NUM_PMTS-1:0]            match_found,
  input  logic [NUM_PMTS*ADDR_WIDTH-1:0] match_addr,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_hit,
  output logic                           resp_multi,
  output logic [PMT_ID_WIDTH-1:0]        resp_pmt_id,
  output logic [ADDR_WIDTH-1:0]          resp_addr,
  output logic [7:0]                     resp_lmt_id,
  output logic [31:0]                    cnt_lookup,
  output logic [31:0]                    cnt_hit
);

  localparam int CW = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEARCH, S_WAIT, S_SAMPLE, S_RESP
  } state_t;

  state_t                  state;
  logic [NUM_PMTS-1:0]     own_mask;
  logic [NUM_PMTS-1:0]     own_mask_d;
  logic [NUM_PMTS-1:0]     hits;
  logic [DATA_WIDTH-1:0]   key_q;
  logic [7:0]              lmt_q;
  logic [CW-1:0]           wait_cnt;
  logic [31:0]             cnt_lookup_q;
  logic [31:0]             cnt_hit_q;
  logic                    hit_d;
  logic                    multi_d;
  logic [PMT_ID_WIDTH-1:0] id_d;
  logic [ADDR_WIDTH-1:0]   addr_d;

  always_comb begin
    own_mask_d = '0;
    for (int i = 0; i < NUM_PMTS; i++)
      own_mask_d[i] = pmt_used[i] && (pmt_lmt_id[i*8 +: 8] == req_lmt_id);
  end

  assign hits    = match_found & own_mask;
  assign hit_d   = |hits;
  assign multi_d = |(hits & (hits - NUM_PMTS'(1)));

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    id_d   = '0;
    addr_d = '0;
    for (int i = NUM_PMTS - 1; i >= 0; i--) begin
      if (hits[i]) begin
        id_d   = PMT_ID_WIDTH'(i);
        addr_d = match_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign search_key = {NUM_PMTS{key_q}};
  assign cnt_lookup = cnt_lookup_q;
  assign cnt_hit    = cnt_hit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      search_en    <= '0;
      own_mask     <= '0;
      key_q        <= '0;
      lmt_q        <= '0;
      wait_cnt     <= '0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_multi   <= 1'b0;
      resp_pmt_id  <= '0;
      resp_addr    <= '0;
      resp_lmt_id  <= '0;
      cnt_lookup_q <= '0;
      cnt_hit_q    <= '0;
    end else begin
      search_en <= '0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            key_q     <= req_key;
            lmt_q     <= req_lmt_id;
            own_mask  <= own_mask_d;
            search_en <= own_mask_d;
            wait_cnt  <= CW'(SEARCH_LAT - 1);
            req_ready <= 1'b0;
            state     <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (wait_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_SAMPLE;
          else wait_cnt <= wait_cnt - CW'(1);
        end
        S_SAMPLE: begin
          resp_valid  <= 1'b1;
          resp_hit    <= hit_d;
          resp_multi  <= multi_d;
          resp_pmt_id <= id_d;
          resp_addr   <= addr_d;
          resp_lmt_id <= lmt_q;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
            if (cnt_lookup_q != 32'hFFFF_FFFF) cnt_lookup_q <= cnt_lookup_q + 32'd1;
            if (resp_hit && (cnt_hit_q != 32'hFFFF_FFFF)) cnt_hit_q <= cnt_hit_q + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
